// File: rtl/tank_pkg.sv
// Shared keycode, facing and AI state definitions for the tank
// controller, the AI opponent and the top level.
package tank_pkg;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHASE    = 3'd1,
        AIM      = 3'd2,
        FIRE     = 3'd3,
        COOLDOWN = 3'd4,
        WANDER   = 3'd5
    } ai_state_t;

    function automatic logic [7:0] dir_key(input logic [2:0] dir);
        logic [7:0] k;
        k = KEY_NONE;
        case (dir)
            DIR_UP:    k = KEY_W;
            DIR_RIGHT: k = KEY_D;
            DIR_LEFT:  k = KEY_A;
            DIR_DOWN:  k = KEY_S;
            default:   k = KEY_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), one step per advance pulse.
// A zero seed would lock up, so it is replaced by 1.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        advance,
    output logic [15:0] state
);

    localparam logic [15:0] INIT = (SEED == 16'h0) ? 16'h0001 : SEED;
    localparam logic [15:0] TAPS = 16'hB400;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state <= INIT;
        else if (advance)
            state <= {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0);
    end

endmodule

// File: rtl/ai_tank_keygen.sv
// Computer opponent: chases the player, aligns on one axis, turns to
// face the player and fires, emitting one keycode per video frame.
module ai_tank_keygen
    import tank_pkg::*;
#(
    parameter int          DECIDE_FRAMES   = 8,
    parameter logic [9:0]  ALIGN_TOL       = 10'd4,
    parameter int          FIRE_FRAMES     = 2,
    parameter int          COOLDOWN_FRAMES = 30,
    parameter int          WANDER_FRAMES   = 16,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       enable,
    input  logic [9:0] player_X,
    input  logic [9:0] player_Y,
    input  logic [9:0] self_X,
    input  logic [9:0] self_Y,
    input  logic [2:0] self_dir,
    input  logic [1:0] self_hit,
    output logic [7:0] keycode,
    output logic [2:0] state_dbg
);

    localparam int AIM_TRIES = 4;
    localparam int M1 = (DECIDE_FRAMES > FIRE_FRAMES) ? DECIDE_FRAMES : FIRE_FRAMES;
    localparam int M2 = (M1 > COOLDOWN_FRAMES) ? M1 : COOLDOWN_FRAMES;
    localparam int M3 = (M2 > WANDER_FRAMES) ? M2 : WANDER_FRAMES;
    localparam int MAXP = (M3 > AIM_TRIES) ? M3 : AIM_TRIES;
    localparam int CW = $clog2(MAXP + 1);

    localparam logic [CW-1:0] DEC_LAST  = CW'(DECIDE_FRAMES - 1);
    localparam logic [CW-1:0] AIM_LAST  = CW'(AIM_TRIES - 1);
    localparam logic [CW-1:0] FIRE_LAST = CW'(FIRE_FRAMES - 1);
    localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN_FRAMES - 1);
    localparam logic [CW-1:0] WAN_LAST  = CW'(WANDER_FRAMES - 1);
    localparam logic [10:0]   TOL       = {1'b0, ALIGN_TOL};

    ai_state_t     st, st_n;
    logic [CW-1:0] fcnt, fcnt_n;
    logic [CW-1:0] ph, ph_n;
    logic [2:0]    tgt, tgt_n;
    logic [7:0]    key_n;
    logic          fs1, fs2, fe;
    logic [15:0]   rnd;
    logic          unused_rnd;

    logic [10:0] dx, dy, adx, ady;
    logic        x_al, y_al, hit_ok;
    logic [2:0]  aim_v, aim_h;
    logic [7:0]  chase_key, wander_key;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fs1 <= 1'b0;
            fs2 <= 1'b0;
        end else begin
            fs1 <= frame_clk;
            fs2 <= fs1;
        end
    end

    assign fe = fs1 & ~fs2;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .Clk     (Clk),
        .Reset   (Reset),
        .advance (fe),
        .state   (rnd)
    );

    assign unused_rnd = ^rnd[15:5];

    // Deltas are 11-bit two's complement; magnitude never exceeds 1023.
    assign dx  = {1'b0, player_X} - {1'b0, self_X};
    assign dy  = {1'b0, player_Y} - {1'b0, self_Y};
    assign adx = dx[10] ? (~dx + 11'd1) : dx;
    assign ady = dy[10] ? (~dy + 11'd1) : dy;

    assign x_al   = (adx <= TOL);
    assign y_al   = (ady <= TOL);
    assign hit_ok = (self_hit == 2'b00);
    assign aim_v  = dy[10] ? DIR_UP : DIR_DOWN;
    assign aim_h  = dx[10] ? DIR_LEFT : DIR_RIGHT;

    always_comb begin
        chase_key = KEY_NONE;
        if (adx <= ady)
            chase_key = dx[10] ? KEY_A : KEY_D;
        else
            chase_key = dy[10] ? KEY_W : KEY_S;
    end

    always_comb begin
        wander_key = KEY_W;
        case (rnd[4:3])
            2'd0: wander_key = KEY_W;
            2'd1: wander_key = KEY_S;
            2'd2: wander_key = KEY_A;
            default: wander_key = KEY_D;
        endcase
    end

    always_comb begin
        st_n   = st;
        fcnt_n = fcnt;
        ph_n   = ph;
        tgt_n  = tgt;
        key_n  = keycode;
        if (fe) begin
            if (!enable) begin
                st_n   = IDLE;
                fcnt_n = '0;
                ph_n   = '0;
                key_n  = KEY_NONE;
            end else begin
                unique case (st)
                    IDLE: begin
                        st_n   = CHASE;
                        fcnt_n = '0;
                        ph_n   = '0;
                        key_n  = KEY_NONE;
                    end
                    CHASE: begin
                        fcnt_n = (fcnt == DEC_LAST) ? '0 : fcnt + 1'b1;
                        if (fcnt == '0) begin
                            if (x_al && hit_ok) begin
                                st_n   = AIM;
                                tgt_n  = aim_v;
                                key_n  = dir_key(aim_v);
                                fcnt_n = '0;
                                ph_n   = '0;
                            end else if (y_al && hit_ok) begin
                                st_n   = AIM;
                                tgt_n  = aim_h;
                                key_n  = dir_key(aim_h);
                                fcnt_n = '0;
                                ph_n   = '0;
                            end else if (rnd[2:0] == 3'd0) begin
                                st_n   = WANDER;
                                key_n  = wander_key;
                                fcnt_n = '0;
                                ph_n   = '0;
                            end else begin
                                key_n = chase_key;
                            end
                        end
                    end
                    AIM: begin
                        if (self_dir == tgt) begin
                            st_n  = FIRE;
                            ph_n  = '0;
                            key_n = KEY_ENTER;
                        end else if (ph == AIM_LAST) begin
                            st_n   = CHASE;
                            fcnt_n = '0;
                            ph_n   = '0;
                            key_n  = KEY_NONE;
                        end else begin
                            ph_n = ph + 1'b1;
                        end
                    end
                    FIRE: begin
                        if (self_hit == 2'b01 || ph == FIRE_LAST) begin
                            st_n  = COOLDOWN;
                            ph_n  = '0;
                            key_n = KEY_NONE;
                        end else begin
                            ph_n = ph + 1'b1;
                        end
                    end
                    COOLDOWN: begin
                        if (ph == CD_LAST) begin
                            st_n   = CHASE;
                            fcnt_n = '0;
                            ph_n   = '0;
                        end else begin
                            ph_n = ph + 1'b1;
                        end
                    end
                    WANDER: begin
                        if (ph == WAN_LAST) begin
                            st_n   = CHASE;
                            fcnt_n = '0;
                            ph_n   = '0;
                            key_n  = KEY_NONE;
                        end else begin
                            ph_n = ph + 1'b1;
                        end
                    end
                    default: begin
                        st_n   = IDLE;
                        fcnt_n = '0;
                        ph_n   = '0;
                        key_n  = KEY_NONE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            st      <= IDLE;
            fcnt    <= '0;
            ph      <= '0;
            tgt     <= DIR_UP;
            keycode <= KEY_NONE;
        end else begin
            st      <= st_n;
            fcnt    <= fcnt_n;
            ph      <= ph_n;
            tgt     <= tgt_n;
            keycode <= key_n;
        end
    end

    assign state_dbg = st;

endmodule
